// File: rtl/tb_pkg.sv
// Shared types for the simple_alu operand/opcode interface and its sequencer.
package tb_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        DIV = 3'd3,
        MOD = 3'd4
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } seq_state_t;

    // Operations answered locally with an error instead of being issued to the ALU.
    function automatic logic op_rejected(input logic [2:0] mode, input logic b_zero);
        logic rej;
        case (mode)
            ADD, SUB, MUL: rej = 1'b0;
            DIV, MOD:      rej = b_zero;
            default:       rej = 1'b1;
        endcase
        return rej;
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Initiator-side driver for simple_alu: issues one operation, waits the ALU latency, returns the result.
// Optional ALU_SEQ_STATS_EN adds saturating response counters stat_ops / stat_errs.
//
// state | meaning
// IDLE  | op_ready=1, waiting for an operation
// ISSUE | alu_start pulse, latency counter loads
// WAIT  | latency counter runs down, alu_c captured at zero
// RESP  | res_valid=1 until res_ready
module alu_op_sequencer
    import tb_pkg::*;
#(
    parameter int ALU_LATENCY = 1,
    parameter int WIDTH       = ALU_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_mode,
    output logic             alu_start,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_mode,
    input  logic [WIDTH-1:0] alu_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_errs
`endif
);

    seq_state_t state, state_next;
    logic [3:0] cnt;
    logic       reject;

    assign reject = op_rejected(op_mode, op_b == '0);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        alu_start  = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_next = reject ? RESP : ISSUE;
            end
            ISSUE: begin
                alu_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) state_next = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand registers double as the ALU-facing outputs, so they stay put until the next accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_mode <= ADD;
            res_data <= '0;
            res_err  <= 1'b0;
            cnt      <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (reject) begin
                            res_data <= '0;
                            res_err  <= 1'b1;
                        end else begin
                            alu_a    <= op_a;
                            alu_b    <= op_b;
                            alu_mode <= op_mode;
                        end
                    end
                end
                ISSUE: cnt <= 4'(ALU_LATENCY - 1);
                WAIT: begin
                    if (cnt == 4'd0) begin
                        res_data <= alu_c;
                        res_err  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (res_valid && res_ready) begin
            if (res_err) begin
                if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
            end else begin
                if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural one-cycle simple_alu model.
module tb_alu_op_sequencer;
    import tb_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_a, op_b;
    logic [2:0] op_mode;
    logic       alu_start;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_mode;
    logic [7:0] alu_c = 8'd0;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops, stat_errs;
`endif

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    int start_before;

    always #5 clock = ~clock;

    alu_op_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_mode   (op_mode),
        .alu_start (alu_start),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mode  (alu_mode),
        .alu_c     (alu_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_errs (stat_errs)
`endif
    );

    // One-cycle registered ALU: result valid the cycle after the start edge.
    always @(posedge clock) begin
        if (alu_start) begin
            start_cnt <= start_cnt + 1;
            case (alu_mode)
                3'd0: alu_c <= alu_a + alu_b;
                3'd1: alu_c <= alu_a - alu_b;
                3'd2: alu_c <= alu_a * alu_b;
                3'd3: alu_c <= (alu_b != 0) ? alu_a / alu_b : 8'd0;
                3'd4: alu_c <= (alu_b != 0) ? alu_a % alu_b : 8'd0;
                default: alu_c <= 8'd0;
            endcase
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_good(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] mode, input logic [7:0] exp, input logic early);
        op_a = a; op_b = b; op_mode = mode; op_valid = 1'b1; res_ready = early;
        check({tag, "_op_ready"}, op_ready, 1);
        tick;
        op_valid = 1'b0;
        check({tag, "_start_c1"}, alu_start, 1);
        check({tag, "_alu_a"}, alu_a, a);
        check({tag, "_alu_b"}, alu_b, b);
        check({tag, "_alu_mode"}, alu_mode, mode);
        check({tag, "_busy_c1"}, op_ready, 0);
        check({tag, "_valid_c1"}, res_valid, 0);
        tick;
        check({tag, "_start_c2"}, alu_start, 0);
        check({tag, "_valid_c2"}, res_valid, 0);
        check({tag, "_alu_a_c2"}, alu_a, a);
        tick;
        check({tag, "_valid_c3"}, res_valid, 1);
        check({tag, "_data"}, res_data, exp);
        check({tag, "_err"}, res_err, 0);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, res_valid, 0);
        check({tag, "_ready_back"}, op_ready, 1);
    endtask

    task automatic run_err(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] mode);
        start_before = start_cnt;
        op_a = a; op_b = b; op_mode = mode; op_valid = 1'b1; res_ready = 1'b0;
        tick;
        op_valid = 1'b0;
        check({tag, "_valid_c1"}, res_valid, 1);
        check({tag, "_err"}, res_err, 1);
        check({tag, "_data"}, res_data, 0);
        check({tag, "_no_start"}, alu_start, 0);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, res_valid, 0);
        check({tag, "_start_count"}, 16'(start_cnt), 16'(start_before));
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
        op_a = 8'd0; op_b = 8'd0; op_mode = 3'd0;
        tick;
        tick;
        check("rst_alu_start", alu_start, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_mode", alu_mode, ADD);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_err", res_err, 0);
        reset = 1'b0;
        tick;
        check("rst_op_ready", op_ready, 1);

        run_good("add", 8'd100, 8'd55, ADD, 8'd155, 1'b0);
        run_good("mul_ovf", 8'd20, 8'd20, MUL, 8'h90, 1'b0);
        run_good("sub_udf", 8'd5, 8'd10, SUB, 8'd251, 1'b0);
        run_err("div0", 8'd9, 8'd0, DIV);
        run_err("mod0", 8'd9, 8'd0, MOD);
        run_err("illegal", 8'd1, 8'd1, 3'd7);
        run_good("div", 8'd200, 8'd7, DIV, 8'd28, 1'b0);

        // Stalled consumer on a modulo operation: response must hold steady.
        op_a = 8'd17; op_b = 8'd5; op_mode = MOD; op_valid = 1'b1; res_ready = 1'b0;
        tick;
        op_valid = 1'b0;
        tick;
        tick;
        check("mod_valid", res_valid, 1);
        check("mod_data", res_data, 2);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("mod_hold_valid", res_valid, 1);
            check("mod_hold_data", res_data, 2);
            check("mod_hold_busy", op_ready, 0);
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check("mod_drop", res_valid, 0);
        check("mod_ready_back", op_ready, 1);

        // Reset landing in WAIT drops the operation.
        op_a = 8'd200; op_b = 8'd3; op_mode = DIV; op_valid = 1'b1;
        tick;
        op_valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midrst_op_ready", op_ready, 1);
        check("midrst_alu_start", alu_start, 0);
        check("midrst_alu_a", alu_a, 0);
        check("midrst_alu_b", alu_b, 0);
        check("midrst_alu_mode", alu_mode, ADD);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_res_data", res_data, 0);
        check("midrst_res_err", res_err, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("midrst_no_resp", res_valid, 0);
        end

        // res_ready high outside RESP has no effect.
        run_good("add_after_rst", 8'd1, 8'd1, ADD, 8'd2, 1'b1);

`ifdef ALU_SEQ_STATS_EN
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("stat_ops_clr", stat_ops, 0);
        check("stat_errs_clr", stat_errs, 0);
        run_good("st_add", 8'd3, 8'd4, ADD, 8'd7, 1'b0);
        run_err("st_div0", 8'd5, 8'd0, DIV);
        run_good("st_sub", 8'd9, 8'd4, SUB, 8'd5, 1'b0);
        run_err("st_mod0", 8'd5, 8'd0, MOD);
        run_good("st_mul", 8'd3, 8'd3, MUL, 8'd9, 1'b0);
        check("stat_ops", stat_ops, 3);
        check("stat_errs", stat_errs, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
